keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_CNT, default 10000, clocks per row slot (200 us at 50 MHz).
REQ-002 SHALL have parameter DEBOUNCE_N, default 4, consecutive stable row samples required for press and release.
REQ-003 SHALL have parameter REPEAT_N, default 2500, held-key samples between auto-repeat events (used only with the REQ-030 macro).
REQ-004 i_Clk  input  1  system clock, 50 MHz.
REQ-005 i_Rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-006 i_Key_Col  input  4  keypad column sense, active-low (0 = key closed on the driven row), externally pulled up.
REQ-007 o_Key_Row  output  4  row drive, one-cold (exactly one bit 0 at all times).
REQ-008 o_Key_Code  output  4  captured key code {row_idx[1:0], col_idx[1:0]}.
REQ-009 o_Key_Valid  output  1  event pending; held until acknowledged.
REQ-010 i_Key_Ack  input  1  consumer acknowledge; clears o_Key_Valid.
REQ-011 o_Overrun  output  1  one-cycle pulse when a new event overwrites an unacknowledged one.

Function
REQ-012 Tick SHALL be asserted for one cycle when the slot counter equals SCAN_CNT-1; the counter then wraps to 0, otherwise it increments.
REQ-013 i_Key_Col SHALL be sampled only on tick cycles, at the end of each row slot.
REQ-014 The hit column SHALL be the lowest index column reading 0; there is no hit when all columns read 1.
REQ-015 The FSM SHALL have states SCAN, DEBOUNCE, HELD and RELEASE.
REQ-016 SCAN: on tick with no hit, o_Key_Row SHALL rotate left (1110 -> 1101 -> 1011 -> 0111 -> 1110).
REQ-017 SCAN: on tick with a hit, the row SHALL be frozen, the candidate code captured, the stable count set to 1, and the FSM SHALL move to DEBOUNCE.
REQ-018 DEBOUNCE: a tick whose hit column equals the candidate SHALL increment the stable count.
REQ-019 DEBOUNCE: a tick with a different column or no hit SHALL return the FSM to SCAN and rotate the row on that tick.
REQ-020 When the stable count reaches DEBOUNCE_N, an event SHALL be issued (REQ-023) and the FSM SHALL move to HELD.
REQ-021 HELD: a tick where the candidate column bit reads 1 SHALL move the FSM to RELEASE with the release count set to 1; the row stays frozen.
REQ-022 RELEASE: a tick with the bit still 1 SHALL increment the release count, and a tick with the bit 0 SHALL return the FSM to HELD; reaching DEBOUNCE_N SHALL return the FSM to SCAN and rotate the row.
REQ-023 Event: the cycle after the event condition, o_Key_Code SHALL equal the candidate and o_Key_Valid SHALL be 1; latency from the qualifying tick is 1 clock.
REQ-024 o_Key_Valid SHALL clear the cycle after i_Key_Ack=1; an ack while o_Key_Valid=0 SHALL be ignored.
REQ-025 An event issued while o_Key_Valid=1 with no ack in the same cycle SHALL overwrite o_Key_Code, keep o_Key_Valid at 1, and pulse o_Overrun.
REQ-026 An event in the same cycle as an ack SHALL set o_Key_Valid=1 with the new code and SHALL NOT pulse o_Overrun.
REQ-027 Only one key per debounce cycle SHALL be reported; other keys pressed simultaneously SHALL be ignored until release.

Reset
REQ-028 On i_Rst=1 at a clock edge, the following SHALL be set: o_Key_Row=4'b1110, o_Key_Code=0, o_Key_Valid=0, o_Overrun=0, FSM=SCAN, all counters 0.
REQ-029 A reset in any state, including mid-debounce or HELD, SHALL discard the candidate and any pending event with no event emitted.

Configuration
REQ-030 With KEYPAD_REPEAT_EN defined, a repeat counter SHALL increment on each HELD tick; at REPEAT_N an event for the same code SHALL be issued and the counter cleared.
REQ-031 The repeat counter SHALL clear on entry to HELD and whenever the FSM is in RELEASE.
REQ-032 Without KEYPAD_REPEAT_EN, exactly one event per press SHALL be issued and the repeat counter SHALL NOT exist.

Verification (SCAN_CNT=4, DEBOUNCE_N=3, REPEAT_N=5)
REQ-033 Idle: release reset with i_Key_Col=1111 -> o_Key_Row cycles 1110,1101,1011,0111 changing every 4 clocks, o_Key_Valid stays 0.
REQ-034 Press key 6 (row1, col2): drive col2 low only while o_Key_Row=1101 -> o_Key_Code=4'h6, o_Key_Valid=1 one clock after the 3rd stable tick; held until ack, cleared the next cycle; row resumes rotating after 3 released ticks.
REQ-035 Bounce: col2 low for 2 ticks then high -> no event, FSM returns to SCAN, row rotates on the bounce tick.
REQ-036 Overrun: press key 1, no ack, release, press key 8 -> o_Key_Code=4'h8, o_Key_Valid=1, o_Overrun one-cycle pulse; repeat with ack on the event cycle -> no pulse.
REQ-037 Reset mid-DEBOUNCE after 2 stable ticks -> o_Key_Row=1110, o_Key_Valid=0, no event afterwards.
REQ-038 KEYPAD_REPEAT_EN: hold key 0 for 12 ticks past the event -> two further events with code 4'h0, spaced 5 ticks apart; without the macro -> exactly one event.

Source files
------------

// File: rtl/keypad_scan.sv
// keypad_scan -- 4x4 matrix keypad scanner with debounce and a one-deep event register.
//
// One row is driven low at a time. The columns are read once at the end of each
// row slot. A key must read closed for DEBOUNCE_N consecutive slots before it is
// reported. It must then read open for DEBOUNCE_N consecutive slots before scanning
// resumes. While a key is pressed or being released the row stays frozen, so only
// that one key is tracked.
//
// Optional feature: define KEYPAD_REPEAT_EN to enable auto-repeat. While a key is
// held, the same code is reported again every REPEAT_N slots.
//
// Ports
//   i_Clk        system clock
//   i_Rst        synchronous active-high reset
//   i_Key_Col    column sense, active-low, pulled up externally
//   o_Key_Row    row drive, one-cold
//   o_Key_Code   last reported key {row_idx, col_idx}
//   o_Key_Valid  event pending; cleared by i_Key_Ack
//   i_Key_Ack    consumer acknowledge
//   o_Overrun    one-cycle pulse when an unacknowledged event is overwritten
module keypad_scan #(
  parameter int SCAN_CNT   = 10000,
  parameter int DEBOUNCE_N = 4,
  parameter int REPEAT_N   = 2500
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [3:0] i_Key_Col,
  output logic [3:0] o_Key_Row,
  output logic [3:0] o_Key_Code,
  output logic       o_Key_Valid,
  input  logic       i_Key_Ack,
  output logic       o_Overrun
);

  localparam int   CNT_W    = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
  localparam int   DB_W     = $clog2(DEBOUNCE_N + 1);
  // With DEBOUNCE_N <= 1, the first qualifying sample completes debounce on its own.
  localparam logic ONE_SHOT = (DEBOUNCE_N <= 1);

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;

  state_t           r_State;
  logic [CNT_W-1:0] r_Cnt;
  logic [3:0]       r_Row;
  logic [3:0]       r_Cand;
  logic [DB_W-1:0]  r_Stab;
  logic [DB_W-1:0]  r_Rel;
  logic [3:0]       r_Code;
  logic             r_Valid;
  logic             r_Overrun;

  logic             w_Tick;
  logic             w_Hit;
  logic [1:0]       w_HitCol;
  logic [1:0]       w_RowIdx;
  logic             w_CandBit;
  logic [DB_W-1:0]  w_StabNext;
  logic [DB_W-1:0]  w_RelNext;
  logic [3:0]       w_RowRot;
  logic             w_RepEvt;
  logic             w_Event;
  logic [3:0]       w_EvCode;

  // Lowest-index column that reads closed.
  function automatic logic [1:0] f_low_zero(input logic [3:0] v);
    if (!v[0])      f_low_zero = 2'd0;
    else if (!v[1]) f_low_zero = 2'd1;
    else if (!v[2]) f_low_zero = 2'd2;
    else            f_low_zero = 2'd3;
  endfunction

  assign w_Tick     = (r_Cnt == CNT_W'(SCAN_CNT - 1));
  assign w_Hit      = (i_Key_Col != 4'hF);
  assign w_HitCol   = f_low_zero(i_Key_Col);
  assign w_RowIdx   = f_low_zero(r_Row);
  // Column bit of the tracked key; 1 means the key reads open.
  assign w_CandBit  = i_Key_Col[r_Cand[1:0]];
  assign w_StabNext = r_Stab + 1'b1;
  assign w_RelNext  = r_Rel + 1'b1;
  assign w_RowRot   = {r_Row[2:0], r_Row[3]};

`ifdef KEYPAD_REPEAT_EN
  localparam int RP_W = $clog2(REPEAT_N + 1);
  logic [RP_W-1:0] r_Rep;
  logic [RP_W-1:0] w_RepNext;
  assign w_RepNext = r_Rep + 1'b1;
  assign w_RepEvt  = (r_State == S_HELD) && !w_CandBit && (w_RepNext == RP_W'(REPEAT_N));
`else
  assign w_RepEvt  = 1'b0;
`endif

  assign w_Event = w_Tick && (
                   (ONE_SHOT && (r_State == S_SCAN) && w_Hit) ||
                   ((r_State == S_DEBOUNCE) && w_Hit && (w_HitCol == r_Cand[1:0]) &&
                    (w_StabNext >= DB_W'(DEBOUNCE_N))) ||
                   w_RepEvt);
  // In SCAN, the candidate has not been captured yet, so take the code directly.
  assign w_EvCode = (r_State == S_SCAN) ? {w_RowIdx, w_HitCol} : r_Cand;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_State   <= S_SCAN;
      r_Cnt     <= '0;
      r_Row     <= 4'b1110;
      r_Cand    <= '0;
      r_Stab    <= '0;
      r_Rel     <= '0;
      r_Code    <= '0;
      r_Valid   <= 1'b0;
      r_Overrun <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_Rep     <= '0;
`endif
    end else begin
      r_Cnt <= w_Tick ? '0 : r_Cnt + 1'b1;

      // Event register: a new event wins over an ack in the same cycle.
      if (w_Event) begin
        r_Code    <= w_EvCode;
        r_Valid   <= 1'b1;
        r_Overrun <= r_Valid && !i_Key_Ack;
      end else begin
        r_Overrun <= 1'b0;
        if (i_Key_Ack) r_Valid <= 1'b0;
      end

`ifdef KEYPAD_REPEAT_EN
      // The counter is zero whenever the FSM is not in HELD. So every entry to
      // HELD starts the count from zero.
      if (r_State != S_HELD)          r_Rep <= '0;
      else if (w_Tick && !w_CandBit) r_Rep <= w_RepEvt ? '0 : w_RepNext;
`endif

      if (w_Tick) begin
        case (r_State)
          S_SCAN: begin
            if (w_Hit) begin
              r_Cand  <= {w_RowIdx, w_HitCol};
              r_Stab  <= DB_W'(1);
              r_State <= ONE_SHOT ? S_HELD : S_DEBOUNCE;
            end else begin
              r_Row <= w_RowRot;
            end
          end
          S_DEBOUNCE: begin
            if (w_Hit && (w_HitCol == r_Cand[1:0])) begin
              r_Stab <= w_StabNext;
              if (w_StabNext >= DB_W'(DEBOUNCE_N)) r_State <= S_HELD;
            end else begin
              r_Stab  <= '0;
              r_State <= S_SCAN;
              r_Row   <= w_RowRot;
            end
          end
          S_HELD: begin
            if (w_CandBit) begin
              if (ONE_SHOT) begin
                r_State <= S_SCAN;
                r_Row   <= w_RowRot;
              end else begin
                r_Rel   <= DB_W'(1);
                r_State <= S_RELEASE;
              end
            end
          end
          S_RELEASE: begin
            if (w_CandBit) begin
              r_Rel <= w_RelNext;
              if (w_RelNext >= DB_W'(DEBOUNCE_N)) begin
                r_Rel   <= '0;
                r_State <= S_SCAN;
                r_Row   <= w_RowRot;
              end
            end else begin
              r_Rel   <= '0;
              r_State <= S_HELD;
            end
          end
          default: r_State <= S_SCAN;
        endcase
      end
    end
  end

  assign o_Key_Row   = r_Row;
  assign o_Key_Code  = r_Code;
  assign o_Key_Valid = r_Valid;
  assign o_Overrun   = r_Overrun;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan (SCAN_CNT=4, DEBOUNCE_N=3, REPEAT_N=5).
// A small keypad model pulls a column low when its pressed key sits on the driven row.
module tb_keypad_scan;
  localparam int SC = 4;
  localparam int DB = 3;
  localparam int RP = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ack = 1'b0;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  code;
  logic        valid;
  logic        ovr;
  logic [15:0] pressed = '0;
  int          checks = 0;
  int          errors = 0;
  int          tb_cnt = 0;
  int          n_ev;

  always #5 clk = ~clk;

  keypad_scan #(.SCAN_CNT(SC), .DEBOUNCE_N(DB), .REPEAT_N(RP)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Key_Col(col), .o_Key_Row(row),
    .o_Key_Code(code), .o_Key_Valid(valid), .i_Key_Ack(ack), .o_Overrun(ovr)
  );

  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      if (row[r] == 1'b0)
        for (int c = 0; c < 4; c++)
          if (pressed[r*4+c]) col[c] = 1'b0;
  end

  // Slot position seen from outside: counts clocks since reset, wrapping every SC.
  always @(posedge clk) begin
    if (rst)                tb_cnt <= 0;
    else if (tb_cnt == SC-1) tb_cnt <= 0;
    else                    tb_cnt <= tb_cnt + 1;
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Stop at the negedge just before a tick edge.
  task automatic pre_tick();
    int n = 0;
    do begin @(negedge clk); n++; end while (tb_cnt != SC-1 && n < 4*SC);
    if (tb_cnt != SC-1) begin
      checks++; errors++;
      $error("FAIL tick_timeout: observed no tick expected tick within %0d clocks", 4*SC);
    end
  endtask

  // Stop at the negedge just after the next tick edge.
  task automatic next_tick();
    pre_tick();
    @(negedge clk);
  endtask

  task automatic goto_row(input logic [3:0] r);
    int n = 0;
    while (row !== r && n < 8) begin next_tick(); n++; end
    check("goto_row", row, r);
  endtask

  task automatic ack_pulse();
    ack = 1'b1; @(negedge clk); ack = 1'b0;
  endtask

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_row", row, 4'b1110);
    check("rst_valid", valid, 1'b0);
    check("rst_code", code, 4'h0);
    check("rst_ovr", ovr, 1'b0);

    // Idle rotation, one step every SC clocks
    pre_tick();
    check("idle_hold", row, 4'b1110);
    @(negedge clk);
    check("idle_r1", row, 4'b1101);
    next_tick(); check("idle_r2", row, 4'b1011);
    next_tick(); check("idle_r3", row, 4'b0111);
    next_tick(); check("idle_r0", row, 4'b1110);
    check("idle_valid", valid, 1'b0);

    // Press key 6 (row1, col2)
    pressed[6] = 1'b1;
    goto_row(4'b1101);
    next_tick(); check("k6_frozen", row, 4'b1101);
    next_tick(); check("k6_stab2", valid, 1'b0);
    pre_tick();  check("k6_pre_ev", valid, 1'b0);
    @(negedge clk);
    check("k6_valid", valid, 1'b1);
    check("k6_code", code, 4'h6);
    check("k6_ovr", ovr, 1'b0);
    repeat (3) @(negedge clk);
    check("k6_held", valid, 1'b1);
    ack_pulse();
    check("k6_acked", valid, 1'b0);
    ack_pulse();
    check("ack_idle_ignored", valid, 1'b0);
    pressed[6] = 1'b0;
    next_tick(); check("k6_rel1", row, 4'b1101);
    next_tick(); check("k6_rel2", row, 4'b1101);
    next_tick(); check("k6_resume", row, 4'b1011);

    // Bounce: closed for 2 ticks, then open
    pressed[6] = 1'b1;
    goto_row(4'b1101);
    next_tick(); check("bn_frozen", row, 4'b1101);
    next_tick();
    pressed[6] = 1'b0;
    next_tick();
    check("bn_rotate", row, 4'b1011);
    check("bn_valid", valid, 1'b0);
    next_tick(); next_tick();
    check("bn_scan", row, 4'b1110);
    check("bn_noev", valid, 1'b0);

    // Overrun: key 1 left unacknowledged, then key 8
    pressed[1] = 1'b1;
    goto_row(4'b1110);
    repeat (3) next_tick();
    check("k1_valid", valid, 1'b1);
    check("k1_code", code, 4'h1);
    check("k1_ovr", ovr, 1'b0);
    pressed[1] = 1'b0;
    repeat (3) next_tick();
    check("k1_resume", row, 4'b1101);
    pressed[8] = 1'b1;
    goto_row(4'b1011);
    repeat (3) next_tick();
    check("k8_code", code, 4'h8);
    check("k8_valid", valid, 1'b1);
    check("k8_ovr", ovr, 1'b1);
    @(negedge clk);
    check("k8_ovr_pulse", ovr, 1'b0);
    check("k8_valid_kept", valid, 1'b1);

    // Event coinciding with ack: no overrun
    pressed[8] = 1'b0;
    repeat (3) next_tick();
    check("k8_resume", row, 4'b0111);
    pressed[1] = 1'b1;
    goto_row(4'b1110);
    repeat (2) next_tick();
    pre_tick();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("ackev_valid", valid, 1'b1);
    check("ackev_code", code, 4'h1);
    check("ackev_ovr", ovr, 1'b0);
    @(negedge clk);
    check("ackev_ovr2", ovr, 1'b0);

    // Reset mid-debounce with an event still pending
    pressed[1] = 1'b0;
    repeat (3) next_tick();
    pressed[8] = 1'b1;
    goto_row(4'b1011);
    repeat (2) next_tick();
    rst = 1'b1;
    pressed[8] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_row", row, 4'b1110);
    check("mrst_valid", valid, 1'b0);
    check("mrst_code", code, 4'h0);
    repeat (4) next_tick();
    check("mrst_noev", valid, 1'b0);
    check("mrst_row_cycle", row, 4'b1110);

    // Held key 0: auto-repeat when enabled, otherwise a single event
    pressed[0] = 1'b1;
    repeat (3) next_tick();
    check("k0_valid", valid, 1'b1);
    check("k0_code", code, 4'h0);
    ack_pulse();
    check("k0_acked", valid, 1'b0);
    n_ev = 0;
    for (int i = 1; i <= 12; i++) begin
      logic exp_v;
`ifdef KEYPAD_REPEAT_EN
      exp_v = (i == 5) || (i == 10);
`else
      exp_v = 1'b0;
`endif
      next_tick();
      check($sformatf("rep_tick%0d", i), valid, exp_v);
      if (valid === 1'b1) begin
        n_ev++;
        check("rep_code", code, 4'h0);
        ack_pulse();
      end
    end
`ifdef KEYPAD_REPEAT_EN
    check("rep_count", 4'(n_ev), 4'd2);
`else
    check("rep_count", 4'(n_ev), 4'd0);
`endif
    pressed[0] = 1'b0;
    repeat (4) next_tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
